// File: rtl/text_ram_pkg.sv
// Shared definitions for the text framebuffer RAM: fill FSM states and
// default screen geometry.
package text_ram_pkg;

    localparam int SCREEN_COLS  = 80;
    localparam int SCREEN_ROWS  = 60;
    localparam int SCREEN_WORDS = SCREEN_COLS * SCREEN_ROWS;

    // Fill engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/text_ram_fill_ctrl.sv
// Fill engine: walks every address once, producing an internal write port
// that overwrites the whole RAM with a latched value (clear-screen).
module text_ram_fill_ctrl
    import text_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RAM_SIZE   = SCREEN_WORDS,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;

    // State, address counter and latched fill word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            value_q <= value_d;
        end
    end

    // Next state: start only from IDLE, stop on the last address (no wrap)
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        value_d = value_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d = ST_FILL;
                    count_d = '0;
                    value_d = fill_value;
                end
            end
            ST_FILL: begin
                if (count_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: busy only while writing, so DONE already reopens the write port
    always_comb begin
        fill_en   = (state_q == ST_FILL);
        fill_addr = count_q;
        fill_data = value_q;
        busy      = (state_q == ST_FILL);
        done      = (state_q == ST_DONE);
    end

endmodule

// File: rtl/text_ram_fill.sv
// Character/attribute framebuffer RAM: one write port (console writer or
// fill engine), one read port (VGA fetch), byte-lane writes, selectable
// read-during-write behaviour and an optional output register.
module text_ram_fill
    import text_ram_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  RAM_SIZE   = SCREEN_WORDS,
    parameter int  ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int  OUT_REG    = 0,
    parameter int  BYPASS     = 1,
    parameter      ROMFILE    = "",
    localparam int NBYTES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    input  logic                  we,
    input  logic [NBYTES-1:0]     wbe,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  wready,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done
);

    // One extra bit so RAM_SIZE itself is representable for range checks
    localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(RAM_SIZE);

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    logic                  fill_en;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  fill_busy;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_be;

    logic                  raddr_ok;
    logic                  wr_hit;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    text_ram_fill_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_SIZE   (RAM_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_en    (fill_en),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .busy       (fill_busy),
        .done       (done)
    );

    assign busy   = fill_busy;
    assign wready = ~fill_busy;

    // Write port mux: the fill engine owns the port while busy; external
    // writes are dropped then, and out-of-range external addresses ignored
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = din;
        wr_be   = wbe;
        if (fill_en) begin
            wr_en   = 1'b1;
            wr_addr = fill_addr;
            wr_data = fill_data;
            wr_be   = '1;
        end else if (we && ({1'b0, waddr} < SIZE_EXT)) begin
            wr_en = 1'b1;
        end
    end

    // Byte-lane write into the array; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Array lookup; out-of-range read addresses return zero
    always_comb begin
        raddr_ok = ({1'b0, raddr} < SIZE_EXT);
        wr_hit   = wr_en && (wr_addr == raddr);
        old_word = '0;
        if (raddr_ok) begin
            old_word = mem[raddr];
        end
    end

    // Per-lane bypass of same-cycle write data when BYPASS is selected
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        assign rd_word[gi*8 +: 8] = ((BYPASS != 0) && wr_hit && wr_be[gi])
                                    ? wr_data[gi*8 +: 8] : old_word[gi*8 +: 8];
    end

    // First read stage: capture data on a request, valid follows re
    always_comb begin
        rd_data_d  = re ? rd_word : rd_data_q;
        rd_valid_d = re;
    end

    // First read stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        // Extra output stage for timing closure towards the VGA fetch
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_data_q  <= rd_data_q;
                out_valid_q <= rd_valid_q;
            end
        end

        assign dout   = out_data_q;
        assign dvalid = out_valid_q;
    end else begin : g_no_out_reg
        assign dout   = rd_data_q;
        assign dvalid = rd_valid_q;
    end

endmodule
